// File: rtl/pt_pkg.sv
// Shared constants and helpers for the platform scroller: game-state code,
// LFSR polynomial, default play-field geometry.
package pt_pkg;

  localparam logic [1:0]  ST_PLAY      = 2'd2;
  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam int          SCREEN_H_DEF = 480;
  localparam int          SPACING_DEF  = 48;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = v >> 1;
    if (v[0]) begin
      return shifted ^ LFSR_MASK;
    end else begin
      return shifted;
    end
  endfunction

  // Rotate right by n (taken modulo 16) via a doubled word.
  function automatic logic [15:0] rotr16(input logic [15:0] v, input int unsigned n);
    logic [31:0] dbl;
    dbl = {v, v} >> (n % 32'd16);
    return dbl[15:0];
  endfunction

endpackage

// File: rtl/pt_scroller_if.sv
// Bundle between the game controller (master) and the platform scroller
// (slave): control inputs plus the packed platform view.
interface pt_scroller_if #(
  parameter int NUM_PT = 10,
  parameter int Y_W    = 9,
  parameter int X_W    = 10,
  parameter int ADV_W  = 4
);

  logic [1:0]            state;
  logic                  tick;
  logic [ADV_W-1:0]      adv;
  logic [NUM_PT*Y_W-1:0] pt_y;
  logic [NUM_PT*X_W-1:0] pt_x;
  logic [NUM_PT-1:0]     pt_vis;
  logic                  recycle_pulse;
  logic [15:0]           recycle_cnt;

  modport master (
    output state, tick, adv,
    input  pt_y, pt_x, pt_vis, recycle_pulse, recycle_cnt
  );

  modport slave (
    input  state, tick, adv,
    output pt_y, pt_x, pt_vis, recycle_pulse, recycle_cnt
  );

endinterface

// File: rtl/pt_lfsr.sv
// 16-bit Galois LFSR (right shift, pt_pkg mask) with load and advance;
// a zero seed is promoted to 1 so the register can never lock up.
module pt_lfsr
  import pt_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 16'd0) ? 16'd1 : seed;
    end else if (advance) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/pt_scroller.sv
// Ring of NUM_PT platforms scrolled down on each PLAY frame tick; platforms
// falling off the bottom are re-spawned above their ring predecessor.
module pt_scroller
  import pt_pkg::*;
#(
  parameter int          NUM_PT   = 10,
  parameter int          Y_W      = 9,
  parameter int          X_W      = 10,
  parameter int          ADV_W    = 4,
  parameter int          SCREEN_H = SCREEN_H_DEF,
  parameter int          SPACING  = SPACING_DEF,
  parameter int          X_MIN    = 0,
  parameter int          X_MAX    = 559,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  pt_scroller_if.slave bus
);

  localparam int             X_SPAN = X_MAX - X_MIN + 1;
  localparam int             YW1    = Y_W + 1;
  localparam logic [Y_W:0]   SPC_W  = YW1'(SPACING);
  localparam logic [Y_W-1:0] SCR_W  = Y_W'(SCREEN_H);

  logic        reinit_s;
  logic        step_s;
  logic [15:0] lfsr_s;

  wire [NUM_PT*Y_W-1:0] y_d;
  wire [NUM_PT*X_W-1:0] x_d;
  wire [NUM_PT-1:0]     vis_d;
  wire [NUM_PT-1:0]     off_s;
  wire [NUM_PT-1:0]     rec_s;

  logic [NUM_PT*Y_W-1:0] y_q;
  logic [NUM_PT*X_W-1:0] x_q;
  logic [NUM_PT-1:0]     vis_q;
  logic                  pulse_d, pulse_q;
  logic [15:0]           cnt_d, cnt_q;
  logic [15:0]           n_rec_s;
  logic [16:0]           cnt_sum_s;

  // Leaving PLAY (or reset) re-initialises everything and overrides a tick.
  assign reinit_s = rst || (bus.state != ST_PLAY);
  assign step_s   = !reinit_s && bus.tick;

  pt_lfsr u_lfsr (
    .clk     (clk),
    .load    (reinit_s),
    .advance (step_s),
    .seed    (SEED),
    .value   (lfsr_s)
  );

  for (genvar g = 0; g < NUM_PT; g++) begin : g_pt
    localparam int             P      = (g + NUM_PT - 1) % NUM_PT;
    localparam logic [Y_W-1:0] Y_INIT = Y_W'(SCREEN_H - g * SPACING);
    localparam logic [X_W-1:0] X_INIT = X_W'(X_MIN + ((g * 53) % X_SPAN));

    logic [Y_W-1:0] yi_s, yp_s, y_nxt_s;
    logic [X_W-1:0] xi_s, raw_s, adj_s, newx_s, x_nxt_s;
    logic [Y_W:0]   sum_s;

    assign yi_s = y_q[g*Y_W +: Y_W];
    assign yp_s = y_q[P*Y_W +: Y_W];
    assign xi_s = x_q[g*X_W +: X_W];

    assign off_s[g] = (yi_s >= SCR_W);
    assign sum_s    = {1'b0, yp_s} + YW1'(bus.adv);
    // A predecessor that is off-screen is itself waiting to recycle, so it
    // cannot anchor this platform; the platform parks and retries.
    assign rec_s[g] = off_s[g] && !off_s[P] && (sum_s >= SPC_W) && (yp_s < yi_s);

    // New x: rotated LFSR window folded once into the legal x range.
    always_comb begin
      raw_s = X_W'(rotr16(lfsr_s, g));
      if (raw_s > X_W'(X_MAX - X_MIN)) begin
        adj_s = raw_s - X_W'(X_SPAN);
      end else begin
        adj_s = raw_s;
      end
      newx_s = adj_s + X_W'(X_MIN);
    end

    // Per-platform next position: re-init, scroll, recycle or park.
    always_comb begin
      y_nxt_s = yi_s;
      x_nxt_s = xi_s;
      if (reinit_s) begin
        y_nxt_s = Y_INIT;
        x_nxt_s = X_INIT;
      end else if (step_s) begin
        if (!off_s[g]) begin
          y_nxt_s = yi_s + Y_W'(bus.adv);
        end else if (rec_s[g]) begin
          y_nxt_s = Y_W'(sum_s - SPC_W);
          x_nxt_s = newx_s;
        end else begin
          y_nxt_s = yi_s;
        end
      end else begin
        y_nxt_s = yi_s;
      end
    end

    assign y_d[g*Y_W +: Y_W] = y_nxt_s;
    assign x_d[g*X_W +: X_W] = x_nxt_s;
    assign vis_d[g]          = (y_nxt_s < SCR_W);
  end

  // Score bookkeeping: saturating recycle count and a one-cycle strobe.
  always_comb begin
    n_rec_s   = 16'($countones(rec_s));
    cnt_sum_s = {1'b0, cnt_q} + {1'b0, n_rec_s};
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    if (reinit_s) begin
      cnt_d   = 16'd0;
      pulse_d = 1'b0;
    end else if (step_s) begin
      cnt_d   = cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
      pulse_d = (n_rec_s != 16'd0);
    end else begin
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    y_q     <= y_d;
    x_q     <= x_d;
    vis_q   <= vis_d;
    pulse_q <= pulse_d;
    cnt_q   <= cnt_d;
  end

  assign bus.pt_y          = y_q;
  assign bus.pt_x          = x_q;
  assign bus.pt_vis        = vis_q;
  assign bus.recycle_pulse = pulse_q;
  assign bus.recycle_cnt   = cnt_q;

endmodule
